// File: rtl/calib_slave_fsm.sv
// Slave-side AIB calibration responder: sequences the config/ready handshake,
// qualifies per-channel TX/RX DCC/DLL lock requests and flags a lock timeout.
module calib_slave_fsm #(
  parameter int TOTAL_CHNL_NUM = 24,
  parameter int LOCK_CYCLES    = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_conf_done,
  input  logic [TOTAL_CHNL_NUM-1:0] ns_mac_rdy,
  input  logic [TOTAL_CHNL_NUM-1:0] ns_adapter_rstn,
  input  logic [TOTAL_CHNL_NUM-1:0] ms_tx_dcc_dll_lock_req,
  input  logic [TOTAL_CHNL_NUM-1:0] ms_rx_dcc_dll_lock_req,
  output logic [TOTAL_CHNL_NUM-1:0] sl_tx_transfer_en,
  output logic [TOTAL_CHNL_NUM-1:0] sl_rx_transfer_en,
  output logic                      calib_done,
  output logic                      calib_err,
  output logic [2:0]                state_o
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_CONF  = 3'd1,
    WAIT_READY = 3'd2,
    LOCKING    = 3'd3,
    DONE       = 3'd4,
    ERROR      = 3'd5
  } state_t;

  localparam logic [7:0]  LOCK_LAST = 8'(LOCK_CYCLES - 1);
  localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT_CYCLES - 1);

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  tx_cnt [TOTAL_CHNL_NUM];
  logic [7:0]  rx_cnt [TOTAL_CHNL_NUM];
  logic [15:0] tmo_cnt;
  logic        all_locked;
  logic        stay_locking;

  // Returns {en, cnt}; a dropped request always forces a full re-count.
  function automatic logic [8:0] lock_upd(input logic req, input logic en,
                                          input logic [7:0] cnt);
    logic [8:0] r;
    r = {en, cnt};
    if (!req)
      r = 9'd0;
    else if (!en)
      r = {(cnt == LOCK_LAST), cnt + 8'd1};
    return r;
  endfunction

  assign all_locked   = (&sl_tx_transfer_en) && (&sl_rx_transfer_en);
  assign stay_locking = (state == LOCKING) && (state_nxt == LOCKING);

  always_comb begin
    state_nxt = state;
    if (state != IDLE && !i_conf_done) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:       state_nxt = WAIT_CONF;
        WAIT_CONF:  state_nxt = WAIT_READY;
        WAIT_READY: if ((&ns_mac_rdy) && (&ns_adapter_rstn)) state_nxt = LOCKING;
        LOCKING: begin
          if (all_locked)              state_nxt = DONE;
          else if (!(&ns_adapter_rstn)) state_nxt = WAIT_READY;
          else if (tmo_cnt == TMO_LAST) state_nxt = ERROR;
        end
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      tmo_cnt           <= '0;
      sl_tx_transfer_en <= '0;
      sl_rx_transfer_en <= '0;
      for (int i = 0; i < TOTAL_CHNL_NUM; i++) begin
        tx_cnt[i] <= '0;
        rx_cnt[i] <= '0;
      end
    end else begin
      state <= state_nxt;
      // DONE pins every enable high regardless of what the master does later.
      if (state_nxt == DONE) begin
        sl_tx_transfer_en <= '1;
        sl_rx_transfer_en <= '1;
      end else if (stay_locking) begin
        for (int i = 0; i < TOTAL_CHNL_NUM; i++) begin
          {sl_tx_transfer_en[i], tx_cnt[i]} <=
            lock_upd(ms_tx_dcc_dll_lock_req[i], sl_tx_transfer_en[i], tx_cnt[i]);
          {sl_rx_transfer_en[i], rx_cnt[i]} <=
            lock_upd(ms_rx_dcc_dll_lock_req[i], sl_rx_transfer_en[i], rx_cnt[i]);
        end
      end else begin
        sl_tx_transfer_en <= '0;
        sl_rx_transfer_en <= '0;
        for (int i = 0; i < TOTAL_CHNL_NUM; i++) begin
          tx_cnt[i] <= '0;
          rx_cnt[i] <= '0;
        end
      end
      if (stay_locking)
        tmo_cnt <= (tmo_cnt == 16'hFFFF) ? tmo_cnt : tmo_cnt + 16'd1;
      else
        tmo_cnt <= '0;
    end
  end

  assign state_o    = state;
  assign calib_done = (state == DONE);
  assign calib_err  = (state == ERROR);

endmodule

// File: tb/tb_calib_slave_fsm.sv
// Bench for calib_slave_fsm: directed scenarios plus a random soak, all
// compared against a run-length behavioural model of the calibration rules.
`timescale 1ns/1ps
module tb_calib_slave_fsm;
  localparam int N    = 4;
  localparam int LOCK = 4;
  localparam int TMO  = 64;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         i_conf_done;
  logic [N-1:0] ns_mac_rdy;
  logic [N-1:0] ns_adapter_rstn;
  logic [N-1:0] ms_tx_dcc_dll_lock_req;
  logic [N-1:0] ms_rx_dcc_dll_lock_req;
  logic [N-1:0] sl_tx_transfer_en;
  logic [N-1:0] sl_rx_transfer_en;
  logic         calib_done;
  logic         calib_err;
  logic [2:0]   state_o;

  int n_checks = 0;
  int n_err    = 0;

  calib_slave_fsm #(
    .TOTAL_CHNL_NUM(N),
    .LOCK_CYCLES   (LOCK),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .i_conf_done           (i_conf_done),
    .ns_mac_rdy            (ns_mac_rdy),
    .ns_adapter_rstn       (ns_adapter_rstn),
    .ms_tx_dcc_dll_lock_req(ms_tx_dcc_dll_lock_req),
    .ms_rx_dcc_dll_lock_req(ms_rx_dcc_dll_lock_req),
    .sl_tx_transfer_en     (sl_tx_transfer_en),
    .sl_rx_transfer_en     (sl_rx_transfer_en),
    .calib_done            (calib_done),
    .calib_err             (calib_err),
    .state_o               (state_o)
  );

  always #5 clk = ~clk;

  // Reference model: per-channel run length of consecutive requested LOCKING cycles.
  int           m_state;
  int           m_lcyc;
  int           m_tx_run [N];
  int           m_rx_run [N];
  logic [N-1:0] m_tx_en;
  logic [N-1:0] m_rx_en;

  always @(posedge clk or negedge rst_n) begin : model
    int nxt;
    if (!rst_n) begin
      m_state = 0;
      m_lcyc  = 0;
      m_tx_en = '0;
      m_rx_en = '0;
      for (int i = 0; i < N; i++) begin
        m_tx_run[i] = 0;
        m_rx_run[i] = 0;
      end
    end else begin
      nxt = m_state;
      if (m_state != 0 && !i_conf_done) nxt = 0;
      else if (m_state == 0) nxt = 1;
      else if (m_state == 1) nxt = 2;
      else if (m_state == 2) begin
        if ((&ns_mac_rdy) && (&ns_adapter_rstn)) nxt = 3;
      end else if (m_state == 3) begin
        if ((&m_tx_en) && (&m_rx_en)) nxt = 4;
        else if (!(&ns_adapter_rstn)) nxt = 2;
        else if (m_lcyc + 1 == TMO) nxt = 5;
      end
      if (nxt == 4) begin
        m_tx_en = '1;
        m_rx_en = '1;
      end else if (m_state == 3 && nxt == 3) begin
        for (int i = 0; i < N; i++) begin
          m_tx_run[i] = ms_tx_dcc_dll_lock_req[i] ? m_tx_run[i] + 1 : 0;
          m_rx_run[i] = ms_rx_dcc_dll_lock_req[i] ? m_rx_run[i] + 1 : 0;
          m_tx_en[i]  = (m_tx_run[i] >= LOCK);
          m_rx_en[i]  = (m_rx_run[i] >= LOCK);
        end
      end else begin
        m_tx_en = '0;
        m_rx_en = '0;
        for (int i = 0; i < N; i++) begin
          m_tx_run[i] = 0;
          m_rx_run[i] = 0;
        end
      end
      m_lcyc  = (m_state == 3 && nxt == 3) ? m_lcyc + 1 : 0;
      m_state = nxt;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".state"}, 32'(state_o), 32'(m_state));
    chk({tag, ".tx_en"}, 32'(sl_tx_transfer_en), 32'(m_tx_en));
    chk({tag, ".rx_en"}, 32'(sl_rx_transfer_en), 32'(m_rx_en));
    chk({tag, ".done"},  32'(calib_done), 32'(m_state == 4));
    chk({tag, ".err"},   32'(calib_err),  32'(m_state == 5));
  endtask

  task automatic tick(input string tag);
    @(negedge clk);
    check_model(tag);
  endtask

  task automatic enter_locking(input logic [N-1:0] tx, input logic [N-1:0] rx);
    i_conf_done            = 1'b0;
    ns_mac_rdy             = '0;
    ns_adapter_rstn        = '0;
    ms_tx_dcc_dll_lock_req = tx;
    ms_rx_dcc_dll_lock_req = rx;
    tick("exit");
    tick("exit");
    i_conf_done     = 1'b1;
    ns_mac_rdy      = '1;
    ns_adapter_rstn = '1;
    for (int k = 0; k < 8 && state_o !== 3'd3; k++) tick("enter");
    chk("reach_locking", 32'(state_o), 32'd3);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int offs [N];
    int ch;
    logic [2*N-1:0] stuck;

    rst_n                  = 1'b0;
    i_conf_done            = 1'b0;
    ns_mac_rdy             = '0;
    ns_adapter_rstn        = '0;
    ms_tx_dcc_dll_lock_req = '0;
    ms_rx_dcc_dll_lock_req = '0;
    repeat (2) @(negedge clk);
    check_model("reset");
    chk("reset.state_const", 32'(state_o), 32'd0);

    // Nominal bring-up
    rst_n = 1'b1;
    tick("nom");
    chk("nom.wait_conf", 32'(state_o), 32'd1);
    i_conf_done = 1'b1;
    tick("nom");
    chk("nom.wait_ready", 32'(state_o), 32'd2);
    repeat (2) tick("nom");
    ns_mac_rdy      = '1;
    ns_adapter_rstn = '1;
    tick("nom");
    chk("nom.locking", 32'(state_o), 32'd3);
    tick("nom");
    ms_tx_dcc_dll_lock_req = '1;
    ms_rx_dcc_dll_lock_req = '1;
    repeat (LOCK - 1) tick("nom");
    chk("nom.tx_not_yet", 32'(sl_tx_transfer_en), 32'h0);
    tick("nom");
    chk("nom.tx_locked", 32'(sl_tx_transfer_en), 32'hF);
    chk("nom.rx_locked", 32'(sl_rx_transfer_en), 32'hF);
    chk("nom.still_locking", 32'(state_o), 32'd3);
    tick("nom");
    chk("nom.done", 32'(calib_done), 32'd1);
    ns_mac_rdy             = '0;
    ns_adapter_rstn        = '0;
    ms_tx_dcc_dll_lock_req = '0;
    ms_rx_dcc_dll_lock_req = '0;
    repeat (3) tick("nom.hold");
    chk("nom.hold_state", 32'(state_o), 32'd4);
    chk("nom.hold_tx", 32'(sl_tx_transfer_en), 32'hF);
    chk("nom.hold_rx", 32'(sl_rx_transfer_en), 32'hF);

    // Staggered TX lock
    offs = '{0, 2, 5, 9};
    enter_locking('0, '1);
    for (int c = 0; c < 14; c++) begin
      for (int i = 0; i < N; i++) ms_tx_dcc_dll_lock_req[i] = (c >= offs[i]);
      tick("stag");
      for (int i = 0; i < N; i++)
        chk("stag.tx_bit", 32'(sl_tx_transfer_en[i]), 32'(c >= offs[i] + LOCK - 1));
      chk("stag.state", 32'(state_o), (c == 13) ? 32'd4 : 32'd3);
    end

    // Lock loss on one random RX channel
    enter_locking(4'h7, 4'hF);
    repeat (LOCK) tick("loss");
    chk("loss.rx_full", 32'(sl_rx_transfer_en), 32'hF);
    ch = $urandom_range(N - 1);
    ms_rx_dcc_dll_lock_req[ch] = 1'b0;
    tick("loss");
    chk("loss.rx_drop", 32'(sl_rx_transfer_en), 32'(4'hF & ~(4'h1 << ch)));
    ms_rx_dcc_dll_lock_req[ch] = 1'b1;
    repeat (LOCK - 1) tick("loss");
    chk("loss.rx_recount", 32'(sl_rx_transfer_en), 32'(4'hF & ~(4'h1 << ch)));
    tick("loss");
    chk("loss.rx_relock", 32'(sl_rx_transfer_en), 32'hF);
    chk("loss.no_done", 32'(state_o), 32'd3);

    // Timeout: TX channel 3 never requested
    enter_locking(4'h7, 4'hF);
    repeat (TMO - 1) tick("tmo");
    chk("tmo.before", 32'(state_o), 32'd3);
    tick("tmo");
    chk("tmo.error", 32'(state_o), 32'd5);
    chk("tmo.err_flag", 32'(calib_err), 32'd1);
    chk("tmo.en_clear", 32'({sl_tx_transfer_en, sl_rx_transfer_en}), 32'h0);
    i_conf_done = 1'b0;
    tick("tmo");
    chk("tmo.idle", 32'(state_o), 32'd0);
    chk("tmo.err_clear", 32'(calib_err), 32'd0);

    // Adapter reset mid-lock
    enter_locking(4'hF, 4'h3);
    repeat (LOCK + 1) tick("arst");
    chk("arst.partial_tx", 32'(sl_tx_transfer_en), 32'hF);
    chk("arst.partial_rx", 32'(sl_rx_transfer_en), 32'h3);
    ch = $urandom_range(N - 1);
    ns_adapter_rstn[ch] = 1'b0;
    tick("arst");
    chk("arst.wait_ready", 32'(state_o), 32'd2);
    chk("arst.en_clear", 32'({sl_tx_transfer_en, sl_rx_transfer_en}), 32'h0);
    ns_adapter_rstn = '1;
    tick("arst");
    chk("arst.relocking", 32'(state_o), 32'd3);
    repeat (LOCK - 1) tick("arst");
    chk("arst.recount", 32'(sl_tx_transfer_en), 32'h0);
    tick("arst");
    chk("arst.relock", 32'(sl_tx_transfer_en), 32'hF);
    ms_rx_dcc_dll_lock_req = '1;
    repeat (LOCK) tick("arst");
    chk("arst.rx_full", 32'(sl_rx_transfer_en), 32'hF);
    tick("arst");
    chk("arst.done", 32'(state_o), 32'd4);

    // Asynchronous reset while in DONE
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset.state", 32'(state_o), 32'd0);
    chk("areset.outs", 32'({sl_tx_transfer_en, sl_rx_transfer_en, calib_done, calib_err}), 32'h0);
    check_model("areset");
    @(negedge clk);
    rst_n = 1'b1;

    // Random soak
    stuck = '0;
    for (int k = 0; k < 800; k++) begin
      if (k % 100 == 0) begin
        stuck = '0;
        if ($urandom_range(2) == 0) stuck[$urandom_range(2 * N - 1)] = 1'b1;
      end
      i_conf_done     = ($urandom_range(127) != 0);
      ns_mac_rdy      = '1;
      ns_adapter_rstn = '1;
      if ($urandom_range(31) == 0) begin
        ch = $urandom_range(N - 1);
        ns_mac_rdy[ch] = 1'b0;
      end
      if ($urandom_range(63) == 0) begin
        ch = $urandom_range(N - 1);
        ns_adapter_rstn[ch] = 1'b0;
      end
      for (int i = 0; i < N; i++) begin
        ms_tx_dcc_dll_lock_req[i] = ($urandom_range(15) != 0) && !stuck[i];
        ms_rx_dcc_dll_lock_req[i] = ($urandom_range(15) != 0) && !stuck[N + i];
      end
      tick("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
